// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage arithmetic unit driven by the 4-bit ALU control code.
// Logic, add, sub, slt and arithmetic-right-shift finish in one cycle.
// Signed multiply runs as an iterative shift-add over WIDTH cycles, and
// ready_o is held low while it runs. Every completion is registered and
// marked by a one-cycle done_o pulse.
//
// Ports:
//   clk_i       - clock, all state changes on the rising edge
//   rst_i       - synchronous reset, active low
//   valid_i     - operation presented on ctrl_i/src1_i/src2_i
//   ctrl_i      - ALU control code (AND/OR/ADD/SUB/SLT/MUL/SRA)
//   src1_i      - operand A (shift amount in [4:0] for SRA)
//   src2_i      - operand B (value shifted for SRA)
//   ready_o     - unit can accept an operation this cycle (state IDLE)
//   done_o      - one-cycle pulse, result outputs valid
//   result_o    - registered result (low product word for MUL)
//   hi_o        - registered upper product word, written only by MUL
//   zero_o      - registered result_o == 0
//   overflow_o  - registered signed overflow for ADD/SUB, else 0
//   illegal_o   - one-cycle pulse with done_o for an unknown code
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b1000;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic                 prod_sign;

    logic [WIDTH-1:0]     add_res;
    logic [WIDTH-1:0]     sub_res;
    logic [WIDTH-1:0]     op_result;
    logic                 op_ovf;
    logic                 op_legal;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod_final;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;

    assign ready_o = (state == IDLE);

    // Magnitudes of the operands for the unsigned shift-add core. The most
    // negative value negates to itself, which read as unsigned is exactly
    // its magnitude, so no special case is needed.
    assign abs_a = src1_i[WIDTH-1] ? (~src1_i + 1'b1) : src1_i;
    assign abs_b = src2_i[WIDTH-1] ? (~src2_i + 1'b1) : src2_i;

    // Single-cycle datapath. SLT uses a true signed compare rather than the
    // sign of A-B so it stays correct when the subtraction overflows.
    always_comb begin
        add_res   = src1_i + src2_i;
        sub_res   = src1_i - src2_i;
        op_result = '0;
        op_ovf    = 1'b0;
        op_legal  = 1'b1;
        case (ctrl_i)
            OP_AND: op_result = src1_i & src2_i;
            OP_OR:  op_result = src1_i | src2_i;
            OP_ADD: begin
                op_result = add_res;
                op_ovf    = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                            (add_res[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                op_result = sub_res;
                op_ovf    = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                            (sub_res[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLT: op_result = {{(WIDTH-1){1'b0}},
                                 ($signed(src1_i) < $signed(src2_i))};
            OP_SRA: op_result = $signed(src2_i) >>> src1_i[4:0];
            OP_MUL: op_result = '0;
            default: op_legal = 1'b0;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand into the upper
    // half (keeping its carry) and shift the whole accumulator right. After
    // WIDTH steps the accumulator holds the unsigned product; the sign is
    // applied only on the final step.
    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                     {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
        acc_next   = {mul_sum, acc[WIDTH-1:1]};
        prod_final = prod_sign ? (~acc_next + 1'b1) : acc_next;
    end

    // Control FSM and all registered outputs. done_o/illegal_o default low
    // every edge so they can only ever pulse for a single cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            count      <= '0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            prod_sign  <= 1'b0;
            result_o   <= '0;
            hi_o       <= '0;
            zero_o     <= 1'b1;
            overflow_o <= 1'b0;
            done_o     <= 1'b0;
            illegal_o  <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            illegal_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (ctrl_i == OP_MUL) begin
                            state     <= MUL;
                            count     <= '0;
                            mcand     <= abs_a;
                            mplier    <= abs_b;
                            acc       <= '0;
                            prod_sign <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
                        end else begin
                            result_o   <= op_result;
                            zero_o     <= (op_result == '0);
                            overflow_o <= op_ovf;
                            done_o     <= 1'b1;
                            illegal_o  <= ~op_legal;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST_COUNT) begin
                        state      <= IDLE;
                        count      <= '0;
                        hi_o       <= prod_final[2*WIDTH-1:WIDTH];
                        result_o   <= prod_final[WIDTH-1:0];
                        zero_o     <= (prod_final[WIDTH-1:0] == '0);
                        overflow_o <= 1'b0;
                        done_o     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed testbench for alu_exec_unit. Each scenario task drives its own
// vectors and compares against hand-computed values. Inputs are changed and
// outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [31:0] hi_o;
    logic        zero_o;
    logic        overflow_o;
    logic        illegal_o;

    int checks;
    int errors;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ctrl_i     (ctrl_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .hi_o       (hi_o),
        .zero_o     (zero_o),
        .overflow_o (overflow_o),
        .illegal_o  (illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance past one rising edge and settle.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        valid_i = v;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        step();
        step();
        rst_i = 1'b1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", ready_o); end
        checks++; if (result_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 0", result_o); end
        checks++; if (hi_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi got %h want 0", hi_o); end
        checks++; if (zero_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_zero got %b want 1", zero_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done_o); end
        checks++; if ({overflow_o, illegal_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ovf_ill got %b want 00", {overflow_o, illegal_o}); end
    endtask

    task automatic test_add_sub();
        drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        step();
        checks++; if (result_o !== 32'h8000_0000) begin errors++; $display("[TB] FAIL add_ovf_result got %h want 80000000", result_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL add_ovf_flag got %b want 1", overflow_o); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL add_done got %b want 1", done_o); end
        checks++; if (zero_o !== 1'b0) begin errors++; $display("[TB] FAIL add_zero got %b want 0", zero_o); end
        drive(1'b1, 4'b0110, 32'd5, 32'd5);
        step();
        checks++; if (result_o !== 32'h0) begin errors++; $display("[TB] FAIL sub_result got %h want 0", result_o); end
        checks++; if (zero_o !== 1'b1) begin errors++; $display("[TB] FAIL sub_zero got %b want 1", zero_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL sub_ovf got %b want 0", overflow_o); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL sub_done got %b want 1", done_o); end
        drive(1'b1, 4'b0110, 32'h8000_0000, 32'h0000_0001);
        step();
        checks++; if ({result_o, overflow_o} !== {32'h7FFF_FFFF, 1'b1}) begin errors++; $display("[TB] FAIL sub_ovf got %h/%b want 7fffffff/1", result_o, overflow_o); end
        drive(1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_0F00);
        step();
        checks++; if ({result_o, overflow_o} !== {32'h0000_0FF0, 1'b0}) begin errors++; $display("[TB] FAIL or got %h/%b want 00000ff0/0", result_o, overflow_o); end
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        step();
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL add_done_pulse got %b want 0", done_o); end
        checks++; if (result_o !== 32'h0000_0FF0) begin errors++; $display("[TB] FAIL result_hold got %h want 00000ff0", result_o); end
    endtask

    task automatic test_slt_sra();
        drive(1'b1, 4'b0111, 32'h8000_0000, 32'h0000_0001);
        step();
        checks++; if (result_o !== 32'h1) begin errors++; $display("[TB] FAIL slt_neg got %h want 1", result_o); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL slt_done got %b want 1", done_o); end
        drive(1'b1, 4'b1000, 32'd4, 32'hF000_0000);
        step();
        checks++; if (result_o !== 32'hFF00_0000) begin errors++; $display("[TB] FAIL sra_4 got %h want ff000000", result_o); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL back_to_back_done got %b want 1", done_o); end
        drive(1'b1, 4'b1000, 32'd0, 32'h8000_0001);
        step();
        checks++; if (result_o !== 32'h8000_0001) begin errors++; $display("[TB] FAIL sra_0 got %h want 80000001", result_o); end
        drive(1'b1, 4'b0111, 32'h0000_0001, 32'h8000_0000);
        step();
        checks++; if ({result_o, zero_o} !== {32'h0, 1'b1}) begin errors++; $display("[TB] FAIL slt_false got %h/%b want 0/1", result_o, zero_o); end
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        step();
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL slt_done_pulse got %b want 0", done_o); end
    endtask

    task automatic test_mul(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int edges;
        int busy_bad;
        edges    = 0;
        busy_bad = 0;
        drive(1'b1, 4'b0101, a, b);
        step();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("[TB] FAIL mul_busy_start got %b want 0", ready_o); end
        while (edges < 100) begin
            step();
            edges++;
            if (done_o === 1'b1) break;
            if (ready_o !== 1'b0) busy_bad++;
        end
        checks++; if (edges !== 32) begin errors++; $display("[TB] FAIL mul_latency got %0d want 32", edges); end
        checks++; if (busy_bad !== 0) begin errors++; $display("[TB] FAIL mul_ready_low bad cycles %0d want 0", busy_bad); end
        checks++; if (hi_o !== exp_hi) begin errors++; $display("[TB] FAIL mul_hi got %h want %h", hi_o, exp_hi); end
        checks++; if (result_o !== exp_lo) begin errors++; $display("[TB] FAIL mul_lo got %h want %h", result_o, exp_lo); end
        checks++; if ({zero_o, overflow_o, ready_o} !== {(exp_lo == 32'h0), 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL mul_flags got %b want %b", {zero_o, overflow_o, ready_o}, {(exp_lo == 32'h0), 1'b0, 1'b1}); end
        step();
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL mul_done_pulse got %b want 0", done_o); end
    endtask

    task automatic test_reset_mid_mul();
        int late_done;
        late_done = 0;
        drive(1'b1, 4'b0101, 32'd3, 32'd5);
        step();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (9) step();
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready got %b want 1", ready_o); end
        checks++; if ({result_o, hi_o} !== 64'h0) begin errors++; $display("[TB] FAIL abort_outputs got %h/%h want 0/0", hi_o, result_o); end
        checks++; if ({zero_o, done_o} !== 2'b10) begin errors++; $display("[TB] FAIL abort_zero_done got %b want 10", {zero_o, done_o}); end
        repeat (40) begin
            step();
            if (done_o !== 1'b0) late_done++;
        end
        checks++; if (late_done !== 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", late_done); end
        drive(1'b1, 4'b0010, 32'd2, 32'd3);
        step();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++; if ({result_o, done_o} !== {32'd5, 1'b1}) begin errors++; $display("[TB] FAIL abort_then_add got %h/%b want 5/1", result_o, done_o); end
    endtask

    task automatic test_illegal_busy();
        int edges;
        int early;
        edges = 0;
        early = 0;
        drive(1'b1, 4'b0101, 32'hFFFF_FFFD, 32'd7);
        step();
        drive(1'b1, 4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F);
        while (edges < 100) begin
            step();
            edges++;
            if (done_o === 1'b1) break;
            if (result_o !== 32'h0000_0005) early++;
        end
        checks++; if (edges !== 32) begin errors++; $display("[TB] FAIL busy_latency got %0d want 32", edges); end
        checks++; if (early !== 0) begin errors++; $display("[TB] FAIL busy_ignored result changed %0d times want 0", early); end
        checks++; if ({hi_o, result_o} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("[TB] FAIL busy_mul got %h/%h want ffffffff/ffffffeb", hi_o, result_o); end
        step();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++; if ({result_o, done_o} !== {32'h0F00_0F00, 1'b1}) begin errors++; $display("[TB] FAIL held_and got %h/%b want 0f000f00/1", result_o, done_o); end
        checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL and_hi_hold got %h want ffffffff", hi_o); end
        drive(1'b1, 4'b0011, 32'd5, 32'd6);
        step();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++; if ({illegal_o, done_o} !== 2'b11) begin errors++; $display("[TB] FAIL illegal_pulse got %b want 11", {illegal_o, done_o}); end
        checks++; if ({result_o, zero_o, overflow_o} !== {32'h0, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL illegal_result got %h/%b/%b want 0/1/0", result_o, zero_o, overflow_o); end
        checks++; if ({hi_o, ready_o} !== {32'hFFFF_FFFF, 1'b1}) begin errors++; $display("[TB] FAIL illegal_hi_ready got %h/%b want ffffffff/1", hi_o, ready_o); end
        step();
        checks++; if ({illegal_o, done_o} !== 2'b00) begin errors++; $display("[TB] FAIL illegal_pulse_end got %b want 00", {illegal_o, done_o}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_i  = 1'b0;
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        test_reset();
        test_add_sub();
        test_slt_sra();
        test_mul(32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        test_mul(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        test_mul(32'h0001_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFE_FFFD);
        test_reset_mid_mul();
        test_illegal_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
